// File: rtl/rob_release_scheduler.sv
// Reorder-buffer release scheduler: picks in-order stored responses per row.
// Define ROB_SCHED_RR_EN for round-robin row choice (default: fixed priority).
module rob_release_scheduler #(
  parameter int ID_WIDTH = 4,
  parameter int NUM_ROWS = 4,
  parameter int NUM_COLS = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  stored_valid,
  input  logic [ID_WIDTH-1:0]                   stored_uid,
  input  logic                                  direct_done,
  input  logic [ID_WIDTH-1:0]                   direct_uid,
  output logic                                  rel_req_valid,
  output logic [ID_WIDTH-1:0]                   rel_req_uid,
  input  logic                                  rel_req_ready,
  input  logic                                  rel_done,
  output logic                                  free_req,
  output logic [ID_WIDTH-1:0]                   free_uid,
  input  logic                                  free_ack,
  output logic [NUM_ROWS*$clog2(NUM_COLS)-1:0]  exp_col,
  output logic                                  busy,
  output logic                                  err
);
  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int COL_W = $clog2(NUM_COLS);
  localparam int UID_W = ROW_W + COL_W;

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_DRAIN, S_FREE
  } state_e;

  state_e                         state_q;
  logic [NUM_ROWS-1:0][COL_W-1:0] ptr_q, ptr_d;
  logic [NUM_ROWS*NUM_COLS-1:0]   wait_q, wait_d;
  logic [ROW_W-1:0]               grow_q;
  logic [COL_W-1:0]               gcol_q;
  logic                           err_q, err_d;

  logic [UID_W-1:0] g_idx, s_idx;
  logic [ROW_W-1:0] s_row, d_row, pick_row;
  logic [COL_W-1:0] s_col, d_col;
  logic             s_hi_bad, rel_fire, in_xfer;
  logic [NUM_ROWS-1:0] hit;

  assign g_idx    = {grow_q, gcol_q};
  assign s_idx    = stored_uid[UID_W-1:0];
  assign s_row    = stored_uid[UID_W-1:COL_W];
  assign s_col    = stored_uid[COL_W-1:0];
  assign d_row    = direct_uid[UID_W-1:COL_W];
  assign d_col    = direct_uid[COL_W-1:0];
  assign s_hi_bad = (stored_uid >> UID_W) != '0;
  assign rel_fire = rel_done && (state_q == S_DRAIN);
  assign in_xfer  = (state_q == S_REQ) || (state_q == S_DRAIN);

  assign rel_req_valid = (state_q == S_REQ);
  assign rel_req_uid   = ID_WIDTH'(g_idx);
  assign free_req      = (state_q == S_FREE);
  assign free_uid      = ID_WIDTH'(g_idx);
  assign exp_col       = ptr_q;
  assign busy          = (state_q != S_IDLE);
  assign err           = err_q;

  // Next pointer/bitmap/error: release and forward updates land before the store check
  always_comb begin
    ptr_d  = ptr_q;
    wait_d = wait_q;
    err_d  = err_q;
    if (rel_done && !rel_fire) err_d = 1'b1;
    if (rel_fire) begin
      wait_d[g_idx]  = 1'b0;
      ptr_d[grow_q]  = ptr_d[grow_q] + 1'b1;
    end
    if (direct_done) begin
      if (d_col != ptr_q[d_row]) err_d = 1'b1;
      if (in_xfer && (d_row == grow_q)) err_d = 1'b1;
      ptr_d[d_row] = ptr_d[d_row] + 1'b1;
    end
    if (stored_valid) begin
      if (s_hi_bad || (rel_fire && (s_idx == g_idx)) ||
          wait_d[s_idx] || (s_col == ptr_d[s_row]))
        err_d = 1'b1;
      else
        wait_d[s_idx] = 1'b1;
    end
  end

  // Per-row head hit and row selection
`ifdef ROB_SCHED_RR_EN
  logic [ROW_W-1:0] last_q, cand;
  always_comb begin
    hit      = '0;
    pick_row = '0;
    cand     = '0;
    for (int r = 0; r < NUM_ROWS; r++)
      hit[r] = wait_q[{ROW_W'(r), ptr_q[r]}];
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      cand = last_q + ROW_W'(i + 1);
      if (hit[cand]) pick_row = cand;
    end
  end
`else
  always_comb begin
    hit      = '0;
    pick_row = '0;
    for (int r = 0; r < NUM_ROWS; r++)
      hit[r] = wait_q[{ROW_W'(r), ptr_q[r]}];
    for (int i = NUM_ROWS - 1; i >= 0; i--)
      if (hit[i]) pick_row = ROW_W'(i);
  end
`endif

  // Pointer, waiting bitmap and sticky error registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q  <= '0;
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  // Release FSM: grant, request handshake, drain, free handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      grow_q  <= '0;
      gcol_q  <= '0;
`ifdef ROB_SCHED_RR_EN
      last_q  <= ROW_W'(NUM_ROWS - 1);
`endif
    end else begin
      unique case (state_q)
        S_IDLE: if (|hit) begin
          grow_q  <= pick_row;
          gcol_q  <= ptr_q[pick_row];
`ifdef ROB_SCHED_RR_EN
          last_q  <= pick_row;
`endif
          state_q <= S_REQ;
        end
        S_REQ:   if (rel_req_ready) state_q <= S_DRAIN;
        S_DRAIN: if (rel_done)      state_q <= S_FREE;
        S_FREE:  if (free_ack)      state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rob_release_scheduler.sv
// Directed bench for rob_release_scheduler.
// Honors ROB_SCHED_RR_EN for the row-order expectation.
module tb_rob_release_scheduler;
  logic       clk = 1'b0;
  logic       rst;
  logic       stored_valid, direct_done;
  logic [3:0] stored_uid, direct_uid;
  logic       rel_req_valid, rel_req_ready, rel_done;
  logic [3:0] rel_req_uid, free_uid;
  logic       free_req, free_ack;
  logic [7:0] exp_col;
  logic       busy, err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rob_release_scheduler #(
    .ID_WIDTH(4), .NUM_ROWS(4), .NUM_COLS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .stored_valid(stored_valid), .stored_uid(stored_uid),
    .direct_done(direct_done), .direct_uid(direct_uid),
    .rel_req_valid(rel_req_valid), .rel_req_uid(rel_req_uid),
    .rel_req_ready(rel_req_ready), .rel_done(rel_done),
    .free_req(free_req), .free_uid(free_uid), .free_ack(free_ack),
    .exp_col(exp_col), .busy(busy), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic store(input logic [3:0] uid);
    stored_valid = 1'b1; stored_uid = uid;
    tick();
    stored_valid = 1'b0;
  endtask

  task automatic direct(input logic [3:0] uid);
    direct_done = 1'b1; direct_uid = uid;
    tick();
    direct_done = 1'b0;
  endtask

  task automatic release_one(input logic [3:0] uid, input int ack_wait);
    int n = 0;
    while (!rel_req_valid && n < 10) begin
      tick(); n++;
    end
    check("req_valid", rel_req_valid, 1);
    check("req_uid", rel_req_uid, uid);
    rel_req_ready = 1'b1;
    tick();
    rel_req_ready = 1'b0;
    check("drain_noreq", rel_req_valid, 0);
    rel_done = 1'b1;
    tick();
    rel_done = 1'b0;
    check("free_req", free_req, 1);
    check("free_uid", free_uid, uid);
    for (int i = 0; i < ack_wait; i++) begin
      tick();
      check("free_hold", {busy, free_req, free_uid}, {2'b11, uid});
    end
    free_ack = 1'b1;
    tick();
    free_ack = 1'b0;
    check("idle_after_free", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    stored_valid = 0; stored_uid = 0;
    direct_done = 0; direct_uid = 0;
    rel_req_ready = 0; rel_done = 0; free_ack = 0;
    #2 rst = 1'b0;
    tick(); tick();
    check("rst_outs", {rel_req_valid, free_req, busy, err}, 0);
    check("rst_expcol", exp_col, 0);
    check("rst_uids", {rel_req_uid, free_uid}, 0);
    rst = 1'b1;
    tick();

    // Basic: store 0x1, forward 0x0
    store(4'h1);
    check("no_early_grant", busy, 0);
    direct(4'h0);
    check("ptr0_after_direct", exp_col, 8'h01);
    tick();
    check("grant_req", {rel_req_valid, rel_req_uid}, {1'b1, 4'h1});
    release_one(4'h1, 0);
    check("ptr0_after_rel", exp_col, 8'h02);

    // Rows 1 and 2
    store(4'h5);
    store(4'h9);
    direct(4'h4);
    direct(4'h8);
    release_one(4'h5, 0);
    release_one(4'h9, 0);
    check("ptrs_r12", exp_col, 8'h2A);

    // Row1 release sets last-granted row 1
    store(4'h7);
    direct(4'h6);
    release_one(4'h7, 0);
    check("ptr1_wrap", exp_col, 8'h22);

    // Stall request, then row0/row2 compete
    store(4'h5);
    store(4'h3);
    store(4'hB);
    direct(4'h4);
    direct(4'h2);
    direct(4'hA);
    for (int i = 0; i < 5; i++) begin
      check("req_hold", {busy, rel_req_valid, rel_req_uid}, {2'b11, 4'h5});
      tick();
    end
    release_one(4'h5, 3);
`ifdef ROB_SCHED_RR_EN
    release_one(4'hB, 0);
    release_one(4'h3, 0);
`else
    release_one(4'h3, 0);
    release_one(4'hB, 0);
`endif
    check("ptrs_after_pair", exp_col, 8'h08);
    check("err_clean", err, 0);

    // Row3 four releases with wrap
    store(4'hD);
    store(4'hE);
    store(4'hF);
    direct(4'hC);
    release_one(4'hD, 0);
    release_one(4'hE, 0);
    release_one(4'hF, 0);
    check("row3_wrap", exp_col, 8'h08);
    store(4'hD);
    direct(4'hC);
    release_one(4'hD, 0);
    check("row3_fourth", exp_col, 8'h88);
    check("err_clean2", err, 0);

    // Duplicate store
    direct(4'h6);
    direct(4'h7);
    store(4'h6);
    check("err_first_store", err, 0);
    store(4'h6);
    check("err_dup", err, 1);
    direct(4'h4);
    direct(4'h5);
    release_one(4'h6, 0);
    tick(); tick(); tick();
    check("no_second_rel", {busy, rel_req_valid}, 0);
    check("err_sticky", err, 1);
    check("ptr1_after_dup", exp_col, 8'h8C);

    // Reset during DRAIN
    store(4'h9);
    direct(4'h8);
    tick();
    check("pre_rst_req", {rel_req_valid, rel_req_uid}, {1'b1, 4'h9});
    rel_req_ready = 1'b1;
    tick();
    rel_req_ready = 1'b0;
    check("in_drain", busy, 1);
    rst = 1'b0;
    #1;
    check("async_rst_outs", {rel_req_valid, free_req, busy, err}, 0);
    check("async_rst_expcol", exp_col, 0);
    tick();
    rst = 1'b1;
    tick();
    store(4'h1);
    direct(4'h0);
    release_one(4'h1, 0);
    check("post_rst_expcol", exp_col, 8'h02);
    check("post_rst_err", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
